// File: rtl/alu_seq.sv
// Command FIFO plus load/settle/capture sequencer wrapped around a combinational ALU.
// Optional sticky flag accumulation is enabled with `define ALU_SEQ_STICKY_FLAGS_EN.
module alu_seq #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic [11:0]                i_cmd_arg0,
  input  logic [11:0]                i_cmd_arg1,
  input  logic [2:0]                 i_cmd_oper,
  output logic [11:0]                o_alu_arg0,
  output logic [11:0]                o_alu_arg1,
  output logic [2:0]                 o_alu_oper,
  input  logic [9:0]                 i_alu_result,
  input  logic [3:0]                 i_alu_flag,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [9:0]                 o_rsp_result,
  output logic [3:0]                 o_rsp_flag,
  output logic [$clog2(DEPTH):0]     o_count,
  input  logic                       i_sticky_clr,
  output logic [3:0]                 o_flag_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [26:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   arg0_q, arg0_d, arg1_q, arg1_d;
  logic [2:0]    oper_q, oper_d;
  logic          valid_q, valid_d;
  logic [9:0]    result_q, result_d;
  logic [3:0]    flag_q, flag_d;
  logic          push, pop, capture, cmd_ready;

  assign cmd_ready = (count_q < (AW + 1)'(DEPTH));
  assign push      = i_cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign capture   = (state_q == S_WAIT) && (cnt_q == CW'(1));

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    arg0_d   = arg0_q;
    arg1_d   = arg1_q;
    oper_d   = oper_q;
    valid_d  = valid_q;
    result_d = result_q;
    flag_d   = flag_q;
    case (state_q)
      S_IDLE: if (pop) begin
        {arg0_d, arg1_d, oper_d} = mem_q[rd_ptr_q];
        cnt_d   = CW'(SETTLE);
        state_d = S_WAIT;
      end
      S_WAIT: if (capture) begin
        result_d = i_alu_result;
        flag_d   = i_alu_flag;
        valid_d  = 1'b1;
        state_d  = S_RESP;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      S_RESP: if (i_rsp_ready) begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage has no reset: emptiness is tracked by the pointers and count alone.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_cmd_arg0, i_cmd_arg1, i_cmd_oper};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      arg0_q   <= '0;
      arg1_q   <= '0;
      oper_q   <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      flag_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      arg0_q   <= arg0_d;
      arg1_q   <= arg1_d;
      oper_q   <= oper_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
  logic [3:0] sticky_q, sticky_d;

  // A clear coinciding with a capture keeps only the freshly captured flags.
  always_comb begin
    sticky_d = i_sticky_clr ? '0 : sticky_q;
    if (capture) sticky_d = sticky_d | i_alu_flag;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sticky_q <= '0;
    else          sticky_q <= sticky_d;
  end

  assign o_flag_sticky = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = i_sticky_clr;
  assign o_flag_sticky     = '0;
`endif

  assign o_cmd_ready  = cmd_ready;
  assign o_count      = count_q;
  assign o_alu_arg0   = arg0_q;
  assign o_alu_arg1   = arg1_q;
  assign o_alu_oper   = oper_q;
  assign o_rsp_valid  = valid_q;
  assign o_rsp_result = result_q;
  assign o_rsp_flag   = flag_q;

endmodule
